// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the scan FSM state encoding and the key-code width function.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        SCAN,
        RESOLVE,
        HOLD
    } state_t;

    function automatic int code_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Synchronous key-code FIFO with push/pop, empty flag and overflow pulse.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module keypad_key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && !do_push;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Parametrised matrix-keypad scanner: row synchroniser, debounce, column
// scan with ghost rejection, and a key-code FIFO on a valid/ready port.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int SETTLE_CYCLES   = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    localparam int CODE_W         = code_w(NUM_ROWS, NUM_COLS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_out,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                multi_key,
    output logic                overflow
);

    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);
    localparam logic [SET_W-1:0] LAST_SET   = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_DONE    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  HOLD_DONE  = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_ROWS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_ROWS-1:0] row_s;
    logic                any_row;

    state_t              state;
    logic [DB_W-1:0]     cnt;
    logic [COL_W-1:0]    col;
    logic [SET_W-1:0]    settle;
    logic                hit;
    logic                multi;
    logic [CODE_W-1:0]   hit_code;
    logic                push;

    logic                seen;
    logic                many;
    logic [ROW_W-1:0]    row_idx;
    logic [CODE_W-1:0]   sample_code;
    logic                take;
    logic                next_hit;
    logic                next_multi;
    logic                fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
        end else begin
            sync_q[0] <= row_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign row_s   = sync_q[SYNC_STAGES-1];
    assign any_row = |row_s;

    always_comb begin
        seen    = 1'b0;
        many    = 1'b0;
        row_idx = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_s[r]) begin
                if (seen)
                    many = 1'b1;
                seen    = 1'b1;
                row_idx = ROW_W'(r);
            end
        end
    end

    // A second single-row hit in a later column is also a multi-key press.
    assign sample_code = CODE_W'(int'(row_idx) * NUM_COLS + int'(col));
    assign take        = seen && !many && !hit;
    assign next_hit    = hit || take;
    assign next_multi  = multi || many || (seen && !many && hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            col_out   <= '1;
            cnt       <= '0;
            col       <= '0;
            settle    <= '0;
            hit       <= 1'b0;
            multi     <= 1'b0;
            hit_code  <= '0;
            push      <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            push      <= 1'b0;
            multi_key <= 1'b0;
            unique case (state)
                IDLE: begin
                    col_out <= '1;
                    if (any_row) begin
                        state <= DEBOUNCE;
                        cnt   <= DB_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!any_row) begin
                        state <= IDLE;
                    end else if (cnt == DB_DONE) begin
                        state   <= SCAN;
                        col     <= '0;
                        settle  <= '0;
                        hit     <= 1'b0;
                        multi   <= 1'b0;
                        col_out <= NUM_COLS'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCAN: begin
                    if (settle == LAST_SET) begin
                        settle <= '0;
                        hit    <= next_hit;
                        multi  <= next_multi;
                        if (take)
                            hit_code <= sample_code;
                        // Outcome is registered here so it is visible during RESOLVE.
                        if (col == LAST_COL) begin
                            state     <= RESOLVE;
                            col_out   <= '1;
                            push      <= next_hit && !next_multi;
                            multi_key <= next_multi;
                        end else begin
                            col     <= col + 1'b1;
                            col_out <= NUM_COLS'(1) << (col + 1'b1);
                        end
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                RESOLVE: begin
                    col_out <= '1;
                    cnt     <= '0;
                    state   <= (multi || hit) ? HOLD : IDLE;
                end
                HOLD: begin
                    col_out <= '1;
                    if (any_row)
                        cnt <= '0;
                    else if (cnt == HOLD_DONE)
                        state <= IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    col_out <= '1;
                end
            endcase
        end
    end

    keypad_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (hit_code),
        .pop       (key_ready),
        .head      (key_code),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign key_valid = !fifo_empty;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a keypad matrix model drives the rows,
// expected codes are queued at stimulus time and popped by a monitor.
module tb_keypad_scan_ctrl;

    localparam int LAT  = 2 + 4 + 4 * 3 + 2;
    localparam int LAT2 = 2 + 4 + 8 * 3 + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        multi_key;
    logic        overflow;

    logic [1:0]  row_in2;
    logic [7:0]  col_out2;
    logic [3:0]  key_code2;
    logic        key_valid2;
    logic        key_ready2;
    logic        multi_key2;
    logic        overflow2;

    logic [15:0] pressed;
    logic [15:0] pressed2;
    logic [3:0]  raw_rows;
    logic        ready_drv;
    logic        rnd_mode;
    logic        rnd_bit;

    int total = 0;
    int bad   = 0;
    int ov_cnt = 0;
    int mk_cnt = 0;
    logic [3:0] exp_q[$];

    keypad_scan_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .multi_key (multi_key),
        .overflow  (overflow)
    );

    keypad_scan_ctrl #(
        .NUM_ROWS (2),
        .NUM_COLS (8)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in2),
        .col_out   (col_out2),
        .key_code  (key_code2),
        .key_valid (key_valid2),
        .key_ready (key_ready2),
        .multi_key (multi_key2),
        .overflow  (overflow2)
    );

    // Keypad matrix: a pressed key shorts its column drive onto its row.
    always_comb begin
        row_in = raw_rows;
        for (int r = 0; r < 4; r++)
            if ((pressed[r*4 +: 4] & col_out) != 4'h0)
                row_in[r] = 1'b1;
    end

    always_comb begin
        row_in2 = 2'b00;
        for (int r = 0; r < 2; r++)
            if ((pressed2[r*8 +: 8] & col_out2) != 8'h00)
                row_in2[r] = 1'b1;
    end

    assign key_ready = rnd_mode ? rnd_bit : ready_drv;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (overflow === 1'b1)
                ov_cnt++;
            if (multi_key === 1'b1)
                mk_cnt++;
            if (key_valid && key_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected got=%0d want=none", key_code);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (key_code !== e) begin
                        bad++;
                        $display("FAIL pop_code got=%0d want=%0d", key_code, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int a, input int b, input int hold);
        pressed[a] = 1'b1;
        if (b >= 0)
            pressed[b] = 1'b1;
        step(hold);
        pressed = '0;
        step(12);
    endtask

    // Reference: a clean single press yields row*4+col unless the buffer is full.
    task automatic press_model(input int code, inout int exp_ov);
        if (exp_q.size() < 4)
            exp_q.push_back(4'(code));
        else
            exp_ov++;
        press(code, -1, LAT + 6);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int ov0;
        int mk0;
        int exp_ov;
        int scan_seen;
        int mk_exp;

        reset      = 1'b1;
        pressed    = '0;
        pressed2   = '0;
        raw_rows   = '0;
        ready_drv  = 1'b0;
        rnd_mode   = 1'b0;
        key_ready2 = 1'b0;
        step(3);
        chk("rst_col", col_out, 4'hf);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_multi", multi_key, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        step(3);

        // Single press (r2,c1), exact latency, no repeat while held.
        pressed[9] = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!key_valid && n < 100);
        chk("latency", n, LAT);
        chk("code9", key_code, 9);
        exp_q.push_back(4'd9);
        step(40 - n);
        pressed = '0;
        step(15);
        chk("held_valid", key_valid, 1);
        ready_drv = 1'b1;
        step(1);
        ready_drv = 1'b0;
        chk("one_entry", key_valid, 0);

        // Bounce shorter than the debounce window.
        scan_seen = 0;
        raw_rows[0] = 1'b1;
        for (int i = 0; i < 28; i++) begin
            if (i == 3)
                raw_rows = '0;
            step(1);
            if (col_out != 4'hf)
                scan_seen++;
        end
        chk("bounce_noscan", scan_seen, 0);
        chk("bounce_col", col_out, 4'hf);
        chk("bounce_valid", key_valid, 0);

        // Ghost rejection: same row, then same column.
        mk0 = mk_cnt;
        press(0, 3, 30);
        chk("multi_row", mk_cnt - mk0, 1);
        chk("multi_row_valid", key_valid, 0);
        mk0 = mk_cnt;
        press(6, 14, 30);
        chk("multi_col", mk_cnt - mk0, 1);
        chk("multi_col_valid", key_valid, 0);

        // Overflow on the fifth press with the consumer stalled.
        ov0 = ov_cnt;
        exp_ov = 0;
        for (int k = 1; k <= 5; k++)
            press_model(k, exp_ov);
        chk("ovf_pulses", ov_cnt - ov0, exp_ov);
        chk("ovf_head", key_code, 1);
        ready_drv = 1'b1;
        step(10);
        ready_drv = 1'b0;
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_empty", key_valid, 0);

        // Full FIFO, push lands in the same cycle as a pop.
        exp_ov = 0;
        press_model(11, exp_ov);
        press_model(12, exp_ov);
        press_model(13, exp_ov);
        press_model(0, exp_ov);
        ov0 = ov_cnt;
        pressed[15] = 1'b1;
        step(LAT - 1);
        ready_drv = 1'b1;
        step(1);
        ready_drv = 1'b0;
        exp_q.push_back(4'd15);
        step(10);
        pressed = '0;
        step(12);
        chk("coinc_noovf", ov_cnt - ov0, 0);
        ready_drv = 1'b1;
        n = 0;
        while (key_valid && n < 10) begin
            step(1);
            n++;
        end
        ready_drv = 1'b0;
        chk("coinc_occ", n, 4);
        chk("coinc_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a scan.
        exp_ov = 0;
        press_model(6, exp_ov);
        pressed[7] = 1'b1;
        step(12);
        reset = 1'b1;
        #1;
        chk("mid_rst_col", col_out, 4'hf);
        chk("mid_rst_valid", key_valid, 0);
        exp_q.delete();
        pressed = '0;
        step(3);
        reset = 1'b0;
        step(12);
        ready_drv = 1'b1;
        exp_ov = 0;
        press_model(10, exp_ov);
        step(3);
        ready_drv = 1'b0;
        chk("rst_recover", exp_q.size(), 0);

        // Randomized presses with a randomly stalling consumer.
        rnd_mode = 1'b1;
        mk0 = mk_cnt;
        mk_exp = 0;
        for (int it = 0; it < 14; it++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                b = a ^ int'($urandom_range(1, 15));
                mk_exp++;
            end else begin
                b = -1;
                exp_q.push_back(4'(a));
            end
            press(a, b, int'($urandom_range(LAT + 2, LAT + 20)));
            step(int'($urandom_range(0, 10)));
        end
        rnd_mode = 1'b0;
        ready_drv = 1'b1;
        step(20);
        ready_drv = 1'b0;
        chk("rnd_multi", mk_cnt - mk0, mk_exp);
        chk("rnd_drained", exp_q.size(), 0);

        // 2x8 matrix: key (r1,c6).
        pressed2[14] = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!key_valid2 && n < 100);
        chk("lat_2x8", n, LAT2);
        chk("code14", key_code2, 14);
        pressed2 = '0;
        step(12);
        chk("multi_2x8", multi_key2, 0);
        chk("ovf_2x8", overflow2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
